alu_share_arb: RTL and testbench

Round-robin arbiter that shares one single-cycle combinational `alu` instance between NREQ issue ports. Each port presents an operation with a valid/ready handshake. The arbiter steers the winner's operands to the ALU and captures `alu_o`/`br_mark` into a one-deep registered response slot. That slot is returned with the requester id and tag under a valid/ready handshake. The block sits between the issue stage(s) and the shared ALU; the ALU itself is instantiated outside and wired to the `alu_*` ports.

---
 rtl/alu_share_arb.sv | 112 +++++++++++
 tb/tb_alu_share_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one external single-cycle ALU between NREQ
// issue ports and returns each result through a one-deep registered response
// slot tagged with the requester id and the request tag.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. On the request side, req_ready is one-hot with the grant (or all zero).
// It is combinational from req_valid and rsp_ready, and it never depends on
// req_valid of the same port in a way that would create a loop. On the
// response side, rsp_valid stays high and rsp_* stay stable until rsp_ready is
// seen high. A drain and a new accept on the same edge overwrite the slot, so
// rsp_valid stays high.
module alu_share_arb #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_ctrl,
    input  logic [32*NREQ-1:0]    req_a,
    input  logic [32*NREQ-1:0]    req_b,
    input  logic [TAG_W*NREQ-1:0] req_tag,
    output logic [3:0]            alu_ctrl,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_res,
    input  logic                  alu_br,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [31:0]           rsp_result,
    output logic                  rsp_br,
    output logic [31:0]           busy_cnt
);

    logic             free;
    logic             gnt_any;
    logic             accept;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   last_q;
    logic [IDW:0]     cand;
    logic [TAG_W-1:0] gnt_tag;

    // Slot can take a new op when empty or being drained this cycle.
    assign free   = !rsp_valid || rsp_ready;
    assign accept = free && gnt_any;

    // Round-robin search starting one past the last accepted port, with wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[IDW-1:0];
            end
        end
    end

    // One-hot ready plus operand steering; everything is zero without an accept.
    always_comb begin
        req_ready = '0;
        alu_ctrl  = '0;
        alu_a     = '0;
        alu_b     = '0;
        gnt_tag   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && gnt_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                alu_ctrl     = req_ctrl[i*4 +: 4];
                alu_a        = req_a[i*32 +: 32];
                alu_b        = req_b[i*32 +: 32];
                gnt_tag      = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Response slot, round-robin pointer and accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_br     <= 1'b0;
            busy_cnt   <= '0;
            last_q     <= IDW'(NREQ - 1);
        end else begin
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= gnt_id;
                rsp_tag    <= gnt_tag;
                rsp_result <= alu_res;
                rsp_br     <= alu_br;
                last_q     <= gnt_id;
                busy_cnt   <= busy_cnt + 32'd1;
            end else if (rsp_ready) begin
                // Data fields keep their last values after a drain.
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU attached to the
// alu_* ports and a queue of expected responses.
module tb_alu_share_arb;

    localparam int NREQ  = 2;
    localparam int TAG_W = 4;
    localparam int IDW   = 1;
    localparam int EW    = IDW + TAG_W + 33;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_NOTEQ = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd9;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [4*NREQ-1:0]     req_ctrl;
    logic [32*NREQ-1:0]    req_a;
    logic [32*NREQ-1:0]    req_b;
    logic [TAG_W*NREQ-1:0] req_tag;
    logic [3:0]            alu_ctrl;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [31:0]           alu_res;
    logic                  alu_br;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_result;
    logic                  rsp_br;
    logic [31:0]           busy_cnt;

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];

    alu_share_arb #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_br(alu_br),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_br(rsp_br),
        .busy_cnt(busy_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural external ALU
    always_comb begin
        alu_res = 32'd0;
        alu_br  = 1'b0;
        case (alu_ctrl)
            OP_ADD:   alu_res = alu_a + alu_b;
            OP_SUB:   alu_res = alu_a - alu_b;
            OP_SLT: begin
                alu_br  = ($signed(alu_a) < $signed(alu_b));
                alu_res = {31'd0, alu_br};
            end
            OP_NOTEQ: begin
                alu_br  = (alu_a != alu_b);
                alu_res = {31'd0, alu_br};
            end
            OP_JUMP: begin
                alu_res = alu_a + alu_b;
                alu_br  = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_port(input int p, input logic v, input logic [3:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t);
        req_valid[p]            = v;
        req_ctrl[p*4 +: 4]      = c;
        req_a[p*32 +: 32]       = a;
        req_b[p*32 +: 32]       = b;
        req_tag[p*TAG_W +: TAG_W] = t;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard
    task automatic push_exp(input logic [IDW-1:0] id, input logic [TAG_W-1:0] tag,
                            input logic [31:0] res, input logic br);
        exp_q.push_back({id, tag, res, br});
    endtask

    task automatic cmp_rsp(input string name, input logic [EW-1:0] e);
        check({name, "_valid"},  64'(rsp_valid), 64'd1);
        check({name, "_id"},     64'(rsp_id), 64'(e[EW-1 -: IDW]));
        check({name, "_tag"},    64'(rsp_tag), 64'(e[EW-IDW-1 -: TAG_W]));
        check({name, "_result"}, 64'(rsp_result), 64'(e[32:1]));
        check({name, "_br"},     64'(rsp_br), 64'(e[0]));
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed a response check with an empty expected queue (expected one entry)", name);
        end else begin
            cmp_rsp(name, exp_q.pop_front());
        end
    endtask

    task automatic peek_check(input string name);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed an empty expected queue (expected one entry)", name);
        end else begin
            cmp_rsp(name, exp_q[0]);
        end
    endtask

    // Watchdog
    initial begin
        #100000;
        fails++;
        $error("FAIL timeout: observed no end of sequence, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Directed sequence
    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester on port 1
        set_port(1, 1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        #1;
        check("t1_req_ready", 64'(req_ready), 64'b10);
        check("t1_alu_a", 64'(alu_a), 64'd5);
        check("t1_alu_b", 64'(alu_b), 64'd7);
        check("t1_alu_ctrl", 64'(alu_ctrl), 64'(OP_ADD));
        push_exp(1'b1, 4'd3, 32'd12, 1'b0);
        step();
        pop_check("t1_rsp");
        check("t1_busy_cnt", 64'(busy_cnt), 64'd1);
        set_port(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        step();
        check("t1_drained", 64'(rsp_valid), 64'd0);
        check("t1_hold_result", 64'(rsp_result), 64'd12);
        check("t1_idle_alu_a", 64'(alu_a), 64'd0);
        check("t1_idle_ready", 64'(req_ready), 64'd0);

        // Both ports continuously valid: grants alternate starting with port 0
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, OP_SUB, 32'(100 + i), 32'(i), 4'(2 * i));
            set_port(1, 1'b1, OP_ADD, 32'(i), 32'd20, 4'(2 * i + 1));
            #1;
            check("t2_req_ready", 64'(req_ready), 64'(1 << (i % 2)));
            if (i % 2 == 0) push_exp(1'b0, 4'(2 * i), 32'd100, 1'b0);
            else            push_exp(1'b1, 4'(2 * i + 1), 32'(i + 20), 1'b0);
            step();
            pop_check("t2_rsp");
        end
        check("t2_busy_cnt", 64'(busy_cnt), 64'd5);

        // Backpressure after one accept
        set_port(0, 1'b1, OP_ADD, 32'd1, 32'd2, 4'd9);
        set_port(1, 1'b1, OP_ADD, 32'd40, 32'd2, 4'd10);
        #1;
        check("t3_first_ready", 64'(req_ready), 64'b01);
        push_exp(1'b0, 4'd9, 32'd3, 1'b0);
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_bp_ready", 64'(req_ready), 64'd0);
            check("t3_bp_alu_ctrl", 64'(alu_ctrl), 64'd0);
            peek_check("t3_bp_hold");
            check("t3_bp_busy", 64'(busy_cnt), 64'd6);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_release_ready", 64'(req_ready), 64'b10);
        check("t3_release_alu_a", 64'(alu_a), 64'd40);
        pop_check("t3_slot_before");
        push_exp(1'b1, 4'd10, 32'd42, 1'b0);
        step();
        pop_check("t3_overwrite");
        check("t3_busy_cnt", 64'(busy_cnt), 64'd7);

        // Branch passthrough on port 0 only
        set_port(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_port(0, 1'b1, OP_NOTEQ, 32'd3, 32'd3, 4'd1);
        push_exp(1'b0, 4'd1, 32'd0, 1'b0);
        step();
        pop_check("t4_noteq");
        set_port(0, 1'b1, OP_JUMP, 32'd100, 32'd4, 4'd2);
        push_exp(1'b0, 4'd2, 32'd104, 1'b1);
        step();
        pop_check("t4_jump");
        set_port(0, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd3);
        push_exp(1'b0, 4'd3, 32'd1, 1'b1);
        step();
        pop_check("t4_slt");

        // Reset while a response is held under backpressure
        set_port(0, 1'b1, OP_ADD, 32'd11, 32'd22, 4'd4);
        set_port(1, 1'b1, OP_ADD, 32'd33, 32'd44, 4'd6);
        rsp_ready = 1'b0;
        step();
        check("t5_pre_valid", 64'(rsp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(rsp_valid), 64'd0);
        check("t5_rst_result", 64'(rsp_result), 64'd0);
        check("t5_rst_br", 64'(rsp_br), 64'd0);
        check("t5_rst_tag", 64'(rsp_tag), 64'd0);
        check("t5_rst_busy", 64'(busy_cnt), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("t5_first_ready", 64'(req_ready), 64'b01);
        push_exp(1'b0, 4'd4, 32'd33, 1'b0);
        step();
        pop_check("t5_rsp");
        check("t5_busy_cnt", 64'(busy_cnt), 64'd1);

        // Counter wrap
        set_port(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        set_port(1, 1'b1, OP_ADD, 32'd7, 32'd8, 4'd5);
        force dut.busy_cnt = 32'hFFFF_FFFF;
        #1 release dut.busy_cnt;
        #1;
        check("t6_req_ready", 64'(req_ready), 64'b10);
        push_exp(1'b1, 4'd5, 32'd15, 1'b0);
        step();
        check("t6_busy_wrap", 64'(busy_cnt), 64'd0);
        pop_check("t6_rsp");

        set_port(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
        step();
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
